// File: rtl/fifo_read_drainer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_drainer
// Purpose  : Reader for the synchronous FIFO. Issues rd_en on credit and
//            replays captured words on a valid/ready stream via a 2-deep buffer.
// Revision : 1.0  initial release
// ============================================================================
module fifo_read_drainer #(
  parameter int FIFO_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [FIFO_WIDTH-1:0]  fifo_data_out,
  input  logic                   fifo_underflow,
  output logic                   rd_en,
  output logic [FIFO_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic                   err_underflow
);

  localparam logic [2:0] c_buf_depth = 3'd2;

  logic                   r_inflight;
  logic [1:0]             r_occ;
  logic [FIFO_WIDTH-1:0]  r_buf [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_rd_count;
  logic                   r_err;

  logic                   w_pop;
  logic                   w_push;
  logic [2:0]             w_credit;

  assign w_pop  = (r_occ != 2'd0) && m_ready;
  // A read the FIFO flags as underflow carries no valid word.
  assign w_push = r_inflight && !fifo_underflow;

  // Slots already spoken for once this cycle's pop leaves; never exceeds 3.
  assign w_credit = {1'b0, r_occ} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign rd_en    = rst_n && en && !fifo_empty && (w_credit < c_buf_depth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_rd_count <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (w_push) begin
        r_buf[r_wr_ptr] <= fifo_data_out;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_rd_count <= r_rd_count + COUNT_WIDTH'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (fifo_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign m_valid       = (r_occ != 2'd0);
  assign m_data        = r_buf[r_rd_ptr];
  assign rd_count      = r_rd_count;
  assign err_underflow = r_err;

endmodule
`default_nettype wire
